operand_sequencer: RTL and testbench

Sequencing controller for the load/compute datapath. It collects `NUM_OPERANDS` operands one per `inputdata_ready` rising edge and steers each into the operand register file. It then issues a single compute request, waits for the datapath's completion with a timeout, and latches and holds the result until `clear`. It replaces the two-state load/Result controller when the datapath needs more than one operand and a bounded compute phase.

---
 rtl/operand_sequencer.sv | 117 +++++++++++
 tb/tb_operand_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_sequencer.sv
// operand_sequencer: gathers NUM_OPERANDS operands on rising edges of
// inputdata_ready, issues one compute request, waits (bounded by TIMEOUT)
// for compute_done, then holds RESULT or ERROR until clear.
module operand_sequencer #(
  parameter  int NUM_OPERANDS = 2,
  parameter  int TIMEOUT      = 64,
  localparam int SEL_W        = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inputdata_ready,
  input  logic             compute_done,
  input  logic             clear,
  output logic             loaddata,
  output logic [SEL_W-1:0] operand_sel,
  output logic             operand_we,
  output logic             compute_start,
  output logic             result_load,
  output logic             result_valid,
  output logic             busy,
  output logic             error
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_OPERANDS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_WAIT,
    S_RESULT,
    S_ERROR
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             prev_ready;
  logic [SEL_W-1:0] n;
  logic [CNT_W-1:0] wait_cnt;
  logic             capture;

  // A capture is a fresh 0->1 of inputdata_ready seen while loading; clear drops it.
  assign capture = inputdata_ready && !prev_ready && (state == S_LOAD) && !clear;

  // Outputs that are pure state decodes.
  assign loaddata      = (state == S_LOAD);
  assign compute_start = (state == S_START);
  assign busy          = (state == S_START) || (state == S_WAIT);
  assign error         = (state == S_ERROR);

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; LOAD leaves one cycle after the last operand's write strobe.
  // NOTE: state_next gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = S_LOAD;
    end else begin
      case (state)
        S_LOAD:   if (operand_we && (operand_sel == LAST_SEL)) state_next = S_START;
        S_START:  state_next = S_WAIT;
        S_WAIT: begin
          if (compute_done)               state_next = S_RESULT;
          else if (wait_cnt == LAST_CNT)  state_next = S_ERROR;
        end
        S_RESULT: state_next = S_RESULT;
        S_ERROR:  state_next = S_ERROR;
        default:  state_next = S_LOAD;
      endcase
    end
  end

  // Edge detector, operand index, wait counter and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_ready   <= 1'b1;
      n            <= '0;
      wait_cnt     <= '0;
      operand_we   <= 1'b0;
      operand_sel  <= '0;
      result_load  <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      prev_ready   <= inputdata_ready;
      operand_we   <= capture;
      result_load  <= !clear && (state == S_WAIT) && compute_done;
      // Valid follows the result_load strobe by one cycle.
      result_valid <= !clear && (state == S_RESULT);
      if (clear) begin
        n           <= '0;
        wait_cnt    <= '0;
        operand_sel <= '0;
      end else begin
        if (capture) begin
          operand_sel <= n;
          n           <= (n == LAST_SEL) ? '0 : n + 1'b1;
        end
        if (state == S_START) begin
          wait_cnt <= '0;
        end else if ((state == S_WAIT) && !compute_done && (wait_cnt != LAST_CNT)) begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer (NUM_OPERANDS=2, TIMEOUT=8).
// Each operation is a stimulus table ending with a clear; the expected
// waveform is derived from the timing rules (capture edges, START/WAIT
// windows, done/timeout resolution) and compared every cycle.
module tb_operand_sequencer;

  localparam int NUM_OPERANDS = 2;
  localparam int TIMEOUT      = 8;
  localparam int SEL_W        = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
  localparam int MAX_LEN      = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             inputdata_ready;
  logic             compute_done;
  logic             clear;
  logic             loaddata;
  logic [SEL_W-1:0] operand_sel;
  logic             operand_we;
  logic             compute_start;
  logic             result_load;
  logic             result_valid;
  logic             busy;
  logic             error;

  typedef struct packed {
    logic             loaddata;
    logic             we;
    logic [SEL_W-1:0] sel;
    logic             start;
    logic             rload;
    logic             rvalid;
    logic             busy;
    logic             err;
  } obs_t;

  obs_t exp_q      [MAX_LEN];
  bit   stim_ready [MAX_LEN];
  bit   stim_done  [MAX_LEN];
  bit   ready_last;
  int   vectors     = 0;
  int   miscompares = 0;

  operand_sequencer #(
    .NUM_OPERANDS (NUM_OPERANDS),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .inputdata_ready (inputdata_ready),
    .compute_done    (compute_done),
    .clear           (clear),
    .loaddata        (loaddata),
    .operand_sel     (operand_sel),
    .operand_we      (operand_we),
    .compute_start   (compute_start),
    .result_load     (result_load),
    .result_valid    (result_valid),
    .busy            (busy),
    .error           (error)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o = {loaddata, operand_we, operand_sel, compute_start,
         result_load, result_valid, busy, error};
    return o;
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o = '0;
    o.loaddata = 1'b1;
    return o;
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < MAX_LEN; i++) begin
      stim_ready[i] = 1'b0;
      stim_done[i]  = 1'b0;
    end
  endtask

  // Expected waveform for one operation: index c is the value just after edge c.
  // The operation starts in LOAD with nothing captured; clear is driven at edge len-1.
  task automatic model_op(input int len);
    int   caps[$];
    int   k, e, w, d, stop;
    bit   prev;
    logic [SEL_W-1:0] cur;
    for (int c = 0; c < len; c++) exp_q[c] = idle_obs();
    prev = ready_last;
    for (int c = 0; c <= len - 2; c++) begin
      if (stim_ready[c] && !prev && (caps.size() < NUM_OPERANDS)) caps.push_back(c);
      prev = stim_ready[c];
    end
    cur = '0;
    k   = 0;
    for (int c = 0; c <= len - 2; c++) begin
      if ((k < caps.size()) && (caps[k] == c)) begin
        exp_q[c].we = 1'b1;
        cur = SEL_W'(k);
        k++;
      end
      exp_q[c].sel = cur;
    end
    if (caps.size() == NUM_OPERANDS) begin
      e = caps[NUM_OPERANDS-1];
      w = e + 2;
      d = -1;
      for (int c = w + 1; (c <= w + TIMEOUT) && (c <= len - 2); c++)
        if ((d < 0) && stim_done[c]) d = c;
      stop = (d >= 0) ? d : w + TIMEOUT;
      if (stop > len - 1) stop = len - 1;
      for (int c = e + 1; c <= len - 2; c++) exp_q[c].loaddata = 1'b0;
      if (e + 1 <= len - 2) exp_q[e+1].start = 1'b1;
      for (int c = e + 1; c < stop; c++) exp_q[c].busy = 1'b1;
      if (d >= 0) begin
        exp_q[d].rload = 1'b1;
        for (int c = d + 1; c <= len - 2; c++) exp_q[c].rvalid = 1'b1;
      end else begin
        for (int c = w + TIMEOUT; c <= len - 2; c++) exp_q[c].err = 1'b1;
      end
    end
  endtask

  // Applies the stimulus table, clears on the last cycle, compares every cycle.
  task automatic run_op(input string name, input int len);
    obs_t act;
    model_op(len);
    for (int c = 0; c < len; c++) begin
      inputdata_ready = stim_ready[c];
      compute_done    = stim_done[c];
      clear           = (c == len - 1);
      @(posedge clk);
      #1;
      act = observe();
      vectors++;
      if (act !== exp_q[c]) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got ld/we/sel/start/rload/rvalid/busy/err=%b/%b/%b/%b/%b/%b/%b/%b need %b/%b/%b/%b/%b/%b/%b/%b",
                 name, c, act.loaddata, act.we, act.sel, act.start, act.rload, act.rvalid, act.busy, act.err,
                 exp_q[c].loaddata, exp_q[c].we, exp_q[c].sel, exp_q[c].start, exp_q[c].rload,
                 exp_q[c].rvalid, exp_q[c].busy, exp_q[c].err);
      end
    end
    clear        = 1'b0;
    compute_done = 1'b0;
    ready_last   = stim_ready[len-1];
  endtask

  task automatic test_reset();
    obs_t act;
    reset = 1'b1; inputdata_ready = 1'b1; compute_done = 1'b0; clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    act = observe();
    vectors++;
    if (act !== idle_obs()) begin
      miscompares++;
      $display("FAIL reset_values: got %b need %b", act, idle_obs());
    end
    reset      = 1'b0;
    ready_last = 1'b1;
    // Ready held high through reset must not capture; later rises do.
    clear_stim();
    for (int c = 0; c <= 2; c++) stim_ready[c] = 1'b1;
    stim_ready[5] = 1'b1; stim_ready[6] = 1'b1; stim_ready[10] = 1'b1;
    run_op("reset_ready_high", 16);
  endtask

  task automatic test_basic();
    clear_stim();
    stim_ready[3] = 1'b1;
    stim_ready[6] = 1'b1;
    stim_done[12] = 1'b1;
    run_op("basic_two_operands", 35);
  endtask

  task automatic test_timeout();
    clear_stim();
    stim_ready[1]  = 1'b1;
    stim_ready[4]  = 1'b1;
    stim_ready[16] = 1'b1;
    stim_ready[20] = 1'b1;
    run_op("timeout_error", 26);
    clear_stim();
    stim_ready[2] = 1'b1;
    stim_ready[4] = 1'b1;
    stim_done[8]  = 1'b1;
    run_op("after_error_clear", 12);
  endtask

  task automatic test_done_edges();
    clear_stim();
    stim_ready[1] = 1'b1;
    stim_ready[3] = 1'b1;
    stim_done[4]  = 1'b1;
    stim_done[5]  = 1'b1;
    stim_done[13] = 1'b1;
    run_op("done_start_and_final", 18);
  endtask

  task automatic test_clear_capture();
    clear_stim();
    stim_ready[2] = 1'b1;
    stim_ready[5] = 1'b1;
    run_op("clear_with_capture", 6);
    clear_stim();
    stim_ready[2] = 1'b1;
    stim_ready[5] = 1'b1;
    stim_done[9]  = 1'b1;
    run_op("after_clear_capture", 14);
  endtask

  task automatic test_async_reset();
    obs_t act;
    inputdata_ready = 1'b0;
    @(posedge clk); #1;
    inputdata_ready = 1'b1;
    @(posedge clk); #1;
    inputdata_ready = 1'b0;
    @(posedge clk); #1;
    inputdata_ready = 1'b1;
    @(posedge clk); #1;
    inputdata_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_busy: got %b need 1", busy);
    end
    #3;
    reset = 1'b1;
    #1;
    act = observe();
    vectors++;
    if (act !== idle_obs()) begin
      miscompares++;
      $display("FAIL async_reset_immediate: got %b need %b", act, idle_obs());
    end
    @(posedge clk); #1;
    reset      = 1'b0;
    ready_last = 1'b1;
    clear_stim();
    stim_ready[2] = 1'b1;
    stim_ready[5] = 1'b1;
    stim_done[10] = 1'b1;
    run_op("post_reset_op", 20);
  endtask

  task automatic test_random();
    int  len;
    bit  no_done;
    for (int op = 0; op < 40; op++) begin
      clear_stim();
      len     = $urandom_range(8, 40);
      no_done = ($urandom_range(0, 9) < 3);
      for (int c = 0; c < len; c++) begin
        stim_ready[c] = ($urandom_range(0, 2) == 0);
        stim_done[c]  = !no_done && ($urandom_range(0, 5) == 0);
      end
      run_op($sformatf("random_op%0d", op), len);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_done_edges();
    test_clear_capture();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
